// File: rtl/spi_slave.sv
// SPI responder: 8-bit, MSB-first, cpol/cpha selectable. Pins are oversampled
// in the system clock domain. Received bytes are presented on a byte-wide
// valid interface, and one response byte can be preloaded into a holding buffer.
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cpol,
  input  logic       i_cpha,
  input  logic       i_sck,
  input  logic       i_ss,
  input  logic       i_mosi,
  output logic       o_miso,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_load,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  output logic       o_busy
);

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_ss_sync, r_mosi_sync, r_flush;
  logic       r_sck_q, r_armed;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx_shift, r_tx_shift, r_tx_buf, r_rx_byte;
  logic       r_tx_ready, r_rx_valid, r_miso;

  logic w_sck_s, w_ss_s, w_mosi_s, w_sync_ok;
  logic w_edge, w_lead, w_trail, w_sample, w_drive;
  logic w_start, w_done, w_byte_start, w_accept;
  logic [7:0] w_tx_data;

  assign w_sck_s   = r_sck_sync[SYNC_STAGES-1];
  assign w_ss_s    = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
  // Synchronizer contents are only real pin samples once the chain has flushed.
  assign w_sync_ok = r_flush[SYNC_STAGES-1];

  assign w_edge   = w_sck_s != r_sck_q;
  assign w_lead   = w_edge && (w_sck_s != i_cpol);
  assign w_trail  = w_edge && (w_sck_s == i_cpol);
  assign w_sample = i_cpha ? w_trail : w_lead;
  assign w_drive  = i_cpha ? w_lead  : w_trail;

  // An empty buffer at byte start sends zeros.
  assign w_tx_data    = r_tx_ready ? 8'h00 : r_tx_buf;
  assign w_accept     = i_tx_load && r_tx_ready;
  assign w_byte_start = w_start || (w_done && !w_ss_s);

  assign o_miso     = r_miso;
  assign o_tx_ready = r_tx_ready;
  assign o_rx_byte  = r_rx_byte;
  assign o_rx_valid = r_rx_valid;
  assign o_busy     = (r_state == S_ACTIVE);

  // Pin synchronizers, sck edge-detect delay and flush tracker.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sck_sync  <= {SYNC_STAGES{i_cpol}};
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_q     <= i_cpol;
      r_flush     <= '0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sck_q     <= w_sck_s;
      r_flush     <= {r_flush[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // A frame may start only after ss has genuinely been seen high.
  always_ff @(posedge i_clk) begin
    if (i_rst)                      r_armed <= 1'b0;
    else if (w_start)               r_armed <= 1'b0;
    else if (w_sync_ok && w_ss_s)   r_armed <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state plus frame-start / byte-complete strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_armed && !w_ss_s) begin
          w_start     = 1'b1;
          w_state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        w_done = w_sample && (r_bit_cnt == 3'd7);
        if (w_ss_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Holding buffer: a load wins over consumption so an empty-buffer start
  // still keeps a byte loaded in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_buf   <= 8'h00;
      r_tx_ready <= 1'b1;
    end else if (w_accept) begin
      r_tx_buf   <= i_tx_byte;
      r_tx_ready <= 1'b0;
    end else if (w_byte_start) begin
      r_tx_ready <= 1'b1;
    end
  end

  // Shift datapath: receive on sample edges, present next bit on drive edges.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= 8'h00;
      r_tx_shift <= 8'h00;
      r_rx_byte  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_miso     <= 1'b0;
    end else begin
      r_rx_valid <= w_done;
      if (w_done) r_rx_byte <= {r_rx_shift[6:0], w_mosi_s};
      if (w_start) begin
        r_bit_cnt <= 3'd0;
        // cpha=0 presents bit7 immediately; cpha=1 waits for the leading edge.
        if (i_cpha) begin
          r_tx_shift <= w_tx_data;
          r_miso     <= 1'b0;
        end else begin
          r_tx_shift <= {w_tx_data[6:0], 1'b0};
          r_miso     <= w_tx_data[7];
        end
      end else if (r_state == S_ACTIVE && !w_ss_s) begin
        if (w_sample) begin
          r_rx_shift <= {r_rx_shift[6:0], w_mosi_s};
          r_bit_cnt  <= r_bit_cnt + 3'd1;
        end
        // New byte is loaded unshifted; the next drive edge presents its bit7.
        if (w_done) begin
          r_tx_shift <= w_tx_data;
        end else if (w_drive) begin
          r_miso     <= r_tx_shift[7];
          r_tx_shift <= {r_tx_shift[6:0], 1'b0};
        end
      end else begin
        r_bit_cnt <= 3'd0;
        r_miso    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: bit-banged SPI master plus a byte-level expectation
// model (master sees the preloaded byte or 0x00, slave sees what was sent).
module tb_spi_slave;
  localparam int HALF = 6;  // sck half period in clk cycles

  logic       clk = 1'b0, rst = 1'b1;
  logic       cpol = 1'b0, cpha = 1'b0, sck = 1'b0, ss = 1'b1, mosi = 1'b0;
  logic       tx_load = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       miso, tx_ready, rx_valid, busy;
  logic [7:0] rx_byte;

  int checks = 0, passed = 0, fails = 0;
  logic [7:0] rx_q[$];
  logic [7:0] mtx[4], mrx[4];

  always #5 clk = ~clk;

  spi_slave #(.SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_cpol(cpol), .i_cpha(cpha), .i_sck(sck),
    .i_ss(ss), .i_mosi(mosi), .o_miso(miso), .i_tx_byte(tx_byte),
    .i_tx_load(tx_load), .o_tx_ready(tx_ready), .o_rx_byte(rx_byte),
    .o_rx_valid(rx_valid), .o_busy(busy)
  );

  // Collect every received byte; a stretched pulse shows up as an extra entry.
  always @(posedge clk) if (rx_valid) rx_q.push_back(rx_byte);

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input logic pol, input logic pha);
    @(negedge clk);
    cpol = pol; cpha = pha; sck = pol;
    clks(8);
  endtask

  task automatic load(input logic [7:0] v);
    @(negedge clk);
    tx_byte = v; tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  // Master side of nb bits of one byte, MSB first.
  task automatic xfer(input logic [7:0] t, input int nb, output logic [7:0] r);
    r = 8'h00;
    if (!cpha) begin
      mosi = t[7];
      for (int i = 7; i >= 8 - nb; i--) begin
        clks(HALF); sck = ~cpol; r[i] = miso;
        clks(HALF); sck = cpol;  if (i > 0) mosi = t[i-1];
      end
    end else begin
      for (int i = 7; i >= 8 - nb; i--) begin
        clks(HALF); sck = ~cpol; mosi = t[i];
        clks(HALF); sck = cpol;  r[i] = miso;
      end
    end
  endtask

  task automatic frame(input int n);
    ss = 1'b0;
    for (int b = 0; b < n; b++) xfer(mtx[b], 8, mrx[b]);
    clks(HALF); ss = 1'b1;
    clks(10);
  endtask

  task automatic check_rx(input string tag, input int n);
    chk({tag, "_nrx"}, 8'(rx_q.size()), 8'(n));
    for (int i = 0; i < n && i < rx_q.size(); i++)
      chk($sformatf("%s_rx%0d", tag, i), rx_q[i], mtx[i]);
    rx_q.delete();
  endtask

  initial begin
    logic [7:0] r, prev, pre;
    logic       has_pre;
    int         cnt, n;

    // Reset state
    clks(5); rst = 1'b0; clks(1);
    chk("rst_miso", {7'd0, miso}, 8'h00);
    chk("rst_ready", {7'd0, tx_ready}, 8'h01);
    chk("rst_rxbyte", rx_byte, 8'h00);
    chk("rst_rxvalid", {7'd0, rx_valid}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    clks(4);

    // Mode 0: preload A5, master sends 3C
    set_mode(1'b0, 1'b0);
    load(8'hA5);
    chk("m0_ready_after_load", {7'd0, tx_ready}, 8'h00);
    mtx[0] = 8'h3C; frame(1);
    chk("m0_mrx", mrx[0], 8'hA5);
    check_rx("m0", 1);
    chk("m0_rxbyte", rx_byte, 8'h3C);
    chk("m0_ready", {7'd0, tx_ready}, 8'h01);

    // Mode 3: preload 81, master sends 7E
    set_mode(1'b1, 1'b1);
    load(8'h81);
    mtx[0] = 8'h7E; frame(1);
    chk("m3_mrx", mrx[0], 8'h81);
    check_rx("m3", 1);
    chk("m3_rxbyte", rx_byte, 8'h7E);

    // Back-to-back with reload after tx_ready rises
    set_mode(1'b0, 1'b0);
    load(8'h11);
    ss = 1'b0; cnt = 0;
    while (!tx_ready && cnt < 20) begin clks(1); cnt++; end
    chk("b2b_ready_latency", 8'(cnt), 8'd3);
    load(8'h22);
    mtx[0] = 8'hDE; mtx[1] = 8'hAD;
    xfer(mtx[0], 8, mrx[0]); xfer(mtx[1], 8, mrx[1]);
    clks(HALF); ss = 1'b1; clks(10);
    chk("b2b_mrx0", mrx[0], 8'h11);
    chk("b2b_mrx1", mrx[1], 8'h22);
    check_rx("b2b", 2);

    // Empty buffer in a random mode
    set_mode(1'($urandom_range(1)), 1'($urandom_range(1)));
    mtx[0] = 8'hFF; frame(1);
    chk("empty_mrx", mrx[0], 8'h00);
    check_rx("empty", 1);

    // Abort after 4 bits
    prev = rx_byte;
    ss = 1'b0;
    xfer(8'($urandom), 4, r);
    ss = 1'b1;
    clks(2); chk("abort_busy_hold", {7'd0, busy}, 8'h01);
    clks(1); chk("abort_busy_fall", {7'd0, busy}, 8'h00);
    clks(6);
    chk("abort_nrx", 8'(rx_q.size()), 8'd0);
    chk("abort_rxbyte", rx_byte, prev);
    rx_q.delete();
    pre = 8'($urandom); load(pre);
    mtx[0] = 8'($urandom); frame(1);
    chk("after_abort_mrx", mrx[0], pre);
    check_rx("after_abort", 1);

    // Reset after 5 bits
    ss = 1'b0;
    xfer(8'($urandom), 5, r);
    rst = 1'b1; clks(1);
    chk("midrst_miso", {7'd0, miso}, 8'h00);
    chk("midrst_ready", {7'd0, tx_ready}, 8'h01);
    chk("midrst_rxbyte", rx_byte, 8'h00);
    chk("midrst_rxvalid", {7'd0, rx_valid}, 8'h00);
    chk("midrst_busy", {7'd0, busy}, 8'h00);
    rst = 1'b0; clks(8);
    chk("midrst_no_frame", {7'd0, busy}, 8'h00);
    chk("midrst_nrx", 8'(rx_q.size()), 8'd0);
    rx_q.delete();
    ss = 1'b1; clks(8);
    pre = 8'($urandom); load(pre);
    mtx[0] = 8'h5A; frame(1);
    chk("post_rst_mrx", mrx[0], pre);
    check_rx("post_rst", 1);
    chk("post_rst_rxbyte", rx_byte, 8'h5A);

    // Random frames: optional preload feeds byte 0 only, later bytes get 0x00
    for (int k = 0; k < 6; k++) begin
      set_mode(1'($urandom_range(1)), 1'($urandom_range(1)));
      n = int'($urandom_range(3, 1));
      has_pre = 1'($urandom_range(1));
      pre = 8'($urandom);
      if (has_pre) load(pre);
      for (int b = 0; b < n; b++) mtx[b] = 8'($urandom);
      frame(n);
      for (int b = 0; b < n; b++)
        chk($sformatf("rnd%0d_mrx%0d", k, b), mrx[b],
            (b == 0 && has_pre) ? pre : 8'h00);
      check_rx($sformatf("rnd%0d", k), n);
      chk($sformatf("rnd%0d_ready", k), {7'd0, tx_ready}, 8'h01);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
# spi_slave

SPI responder for the same 8-bit, MSB-first, mode-selectable protocol our SPI master drives. It runs entirely in the system clock domain. It oversamples the external `sck`, `ss` and `mosi` pins through synchronizers, shifts in one byte per frame and shifts out a preloaded response byte on `miso`. It sits between the board-level SPI pins and the local register/FIFO logic, which sees a simple load/valid byte interface.

## Interface
- `SYNC_STAGES`, 2, synchronizer depth on `sck`, `ss` and `mosi` (minimum 2).
- `clk`  input  1  system clock; one clock only. Requires clk ≥ 8× sck frequency (80 MHz vs 10 MHz nominal).
- `rst`  input  1  synchronous, active-high reset.
- `cpol`  input  1  clock idle level; must be static while `ss` is low.
- `cpha`  input  1  0: sample on leading edge, drive on trailing edge; 1: drive on leading edge, sample on trailing edge.
- `sck`  input  1  SPI clock from master; asynchronous to `clk`.
- `ss`  input  1  active-low slave select; asynchronous.
- `mosi`  input  1  serial data from master.
- `miso`  output  1  serial data to master; driven 0 while deselected (no tristate).
- `tx_byte`  input  8  response byte to transmit.
- `tx_load`  input  1  write strobe; accepted when `tx_load && tx_ready`.
- `tx_ready`  output  1  high when the tx holding buffer is empty.
- `rx_byte`  output  8  last complete received byte; held until the next complete byte.
- `rx_valid`  output  1  one-cycle pulse when `rx_byte` updates.
- `busy`  output  1  high while a frame is active (synchronized `ss` low).

## Operation
- Synchronizers: `sck_s`, `ss_s` and `mosi_s` each pass through SYNC_STAGES flops. `sck_q` is one further delay of `sck_s`.
- Edge detect: edge = `sck_s != sck_q`. Leading edge = `sck_s != cpol`. Trailing edge = `sck_s == cpol`.
- Sample edge: leading if `cpha`=0, trailing if `cpha`=1. Drive edge: the other one.
- Tx holding buffer:
  - An accepted `tx_load` copies `tx_byte` into `tx_buf` and clears `tx_ready` on the next cycle.
  - The buffer is consumed (`tx_ready` set) at each byte start.
  - If the buffer is empty at byte start, the byte transmitted is 0x00.
- FSM states:
  - IDLE: `busy`=0, `miso`=0. On `ss_s` falling: load `tx_shift` from buffer (or 0x00), `bit_cnt`=0, go ACTIVE.
    - `cpha`=0: `miso` = bit7 on entry.
    - `cpha`=1: `miso` stays 0 until the first leading edge.
  - ACTIVE:
    - Each sample edge: `rx_shift` = {`rx_shift`[6:0], `mosi_s`}, `bit_cnt`++.
    - Each drive edge: `miso` = next bit, MSB first.
    - `cpha`=1: the first drive edge of each byte presents bit7.
    - On the 8th sample: `rx_byte` = {`rx_shift`[6:0], `mosi_s`}, `rx_valid` pulses, `bit_cnt` wraps to 0, and the next byte starts immediately (buffer load as above).
    - `cpha`=0: the next byte's bit7 is driven on the 8th trailing edge.
    - On `ss_s` rising: go IDLE.
  - A partial byte (`bit_cnt` ≠ 0) is discarded: no `rx_valid`, `rx_byte` unchanged. A byte start already consumed keeps its `tx_ready` effect.
- Simultaneous `ss_s` rising and the 8th sample edge in the same cycle: the byte completes (`rx_valid` pulses), then go IDLE.
- Simultaneous `tx_load` and byte start in the same cycle:
  - If the buffer is full, the start consumes the old value and the load is refused (`tx_ready` was 0).
  - If the buffer is empty, 0x00 is sent and the new value is accepted for the next byte.
- `cpol`/`cpha` changes while `busy`=1: undefined; not checked.

## Timing
- Reset values: `miso`=0, `tx_ready`=1, `rx_byte`=0x00, `rx_valid`=0, `busy`=0, `tx_buf`=0x00, `bit_cnt`=0, FSM=IDLE. The synchronizer flops reset to `ss`=1 and `sck`=`cpol`.
- Reset asserted mid-frame: state returns to IDLE the next cycle, and the partial byte is lost. After reset releases, a new frame is recognized only after `ss_s` is seen high, then falls.
- Pin-to-action latency: SYNC_STAGES+1 clk cycles (3 by default) from an `sck`/`ss` pin transition to the registered `miso`/`rx_*` update.
- `miso` changes ≤ 3 clk after the drive edge. This is within the half sck period (≥ 4 clk) before the master's sample edge.
- `rx_valid`: exactly 1 cycle wide, 3 clk after the 8th sample edge at the pin. Back-to-back bytes produce pulses 8 sck periods apart.
- `tx_ready` rises 3 clk after `ss` falls and 3 clk after each 8th sample edge.

## Test plan
- Mode 0 (cpol=0, cpha=0): preload 0xA5, master sends 0x3C → master receives 0xA5; `rx_byte`=0x3C with a single `rx_valid` pulse; `tx_ready` returns to 1.
- Mode 3 (cpol=1, cpha=1): preload 0x81, master sends 0x7E → master receives 0x81; `rx_byte`=0x7E. `miso` bit7 must be valid before the first trailing edge.
- Back-to-back with `ss` held low: preload 0x11, reload 0x22 after `tx_ready` rises; master sends 0xDE, 0xAD → master gets 0x11, 0x22; two `rx_valid` pulses with `rx_byte` 0xDE then 0xAD.
- Empty buffer: no `tx_load`, master sends 0xFF → master receives 0x00; `rx_byte`=0xFF.
- Abort: `ss` rises after 4 sck cycles → no `rx_valid`, `rx_byte` keeps its previous value, `busy` falls 3 clk later. The next full frame works normally.
- Reset mid-frame after 5 bits → all outputs at reset values the next cycle. A following frame (after `ss` high, then low) transfers 0x5A correctly.
